// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA-1 job scheduler.
//   - state_e  : scheduler FSM states
//   - WordW    : message word width
//   - NumWords : words per 512-bit block
//   - DigestW  : digest width
//   - BlockW   : assembled block width
package sha1_pkg;

  localparam int unsigned WordW    = 32;
  localparam int unsigned NumWords = 16;
  localparam int unsigned DigestW  = 160;
  localparam int unsigned BlockW   = WordW * NumWords;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StKick,
    StRun,
    StResp
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant.
//   request[1:0] in  : requesters currently asking
//   last         in  : index of the requester served most recently
//   grant[1:0]   out : one-hot grant, or zero when nobody asks
module rr_arb2 (
  input  logic [1:0] request,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = request;
    // On a tie, favour the requester that was not served last.
    if (request == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/sha1_sched.sv
// Arbitrates two requesters onto one external SHA-1 engine: collects a
// 16-word block from the granted requester, pulses the engine reset, runs
// the engine with a timeout, and holds the result until acknowledged.
//   wb_clk_i, reset       : clock, asynchronous active-high reset
//   req_valid/data/ready  : per-requester word offer and acceptance
//   rsp_valid/ack         : per-requester result handshake
//   rsp_digest/rsp_error  : result payload (error = timeout)
//   core_reset/on/msg     : engine control and assembled block
//   core_digest/finish    : engine result
//   busy                  : scheduler is not idle
module sha1_sched
  import sha1_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned NREQ    = 2
) (
  input  logic                    wb_clk_i,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [WordW*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ack,
  output logic [DigestW-1:0]      rsp_digest,
  output logic                    rsp_error,
  output logic                    core_reset,
  output logic                    core_on,
  output logic [BlockW-1:0]       core_msg,
  input  logic [DigestW-1:0]      core_digest,
  input  logic                    core_finish,
  output logic                    busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e              r_state;
  state_e              w_state_d;
  logic [1:0]          r_grant;
  logic [1:0]          w_arb_grant;
  logic                r_last;
  logic [3:0]          r_widx;
  logic [CntW-1:0]     r_cnt;
  logic [BlockW-1:0]   r_msg;
  logic [DigestW-1:0]  r_digest;
  logic                r_error;
  logic                r_rst_hold;
  logic [WordW-1:0]    w_lane;
  logic                w_accept;
  logic                w_timeout;
  logic                w_ack;

  rr_arb2 u_arb (
    .request (req_valid),
    .last    (r_last),
    .grant   (w_arb_grant)
  );

  assign w_lane    = r_grant[1] ? req_data[2*WordW-1:WordW] : req_data[WordW-1:0];
  assign w_accept  = (r_state == StLoad) && |(req_valid & r_grant);
  // Counter holds the number of RUN cycles already completed, so this is the
  // TIMEOUT-th RUN cycle.
  assign w_timeout = (r_cnt == CntW'(TIMEOUT - 1));
  assign w_ack     = (r_state == StResp) && |(rsp_ack & r_grant);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (|req_valid) w_state_d = StLoad;
      StLoad:  if (w_accept && (r_widx == 4'd15)) w_state_d = StKick;
      StKick:  w_state_d = StRun;
      StRun:   if (core_finish || w_timeout) w_state_d = StResp;
      StResp:  if (w_ack) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      r_grant    <= 2'b00;
      r_last     <= 1'b1;
      r_widx     <= 4'd0;
      r_cnt      <= '0;
      r_msg      <= '0;
      r_digest   <= '0;
      r_error    <= 1'b0;
      r_rst_hold <= 1'b1;
    end else begin
      // Keeps the engine in reset for the first cycle after release.
      r_rst_hold <= 1'b0;
      r_cnt      <= '0;
      case (r_state)
        StIdle: begin
          if (|req_valid) r_grant <= w_arb_grant;
        end
        StLoad: begin
          if (w_accept) begin
            r_msg[{r_widx, 5'd0} +: WordW] <= w_lane;
            r_widx <= r_widx + 4'd1;
          end
        end
        StRun: begin
          if (r_cnt != '1) r_cnt <= r_cnt + CntW'(1);
          if (core_finish) begin
            r_digest <= core_digest;
            r_error  <= 1'b0;
          end else if (w_timeout) begin
            r_digest <= '0;
            r_error  <= 1'b1;
          end
        end
        StResp: begin
          if (w_ack) r_last <= r_grant[1];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    core_on    = 1'b0;
    core_reset = r_rst_hold;
    busy       = (r_state != StIdle);
    case (r_state)
      StLoad:  req_ready  = r_grant;
      StKick:  core_reset = 1'b1;
      StRun:   core_on    = 1'b1;
      StResp:  rsp_valid  = r_grant;
      default: ;
    endcase
  end

  assign core_msg   = r_msg;
  assign rsp_digest = r_digest;
  assign rsp_error  = r_error;

endmodule

// File: tb/tb_sha1_sched.sv
// Directed bench for sha1_sched with a behavioural engine model.
module tb_sha1_sched;
  import sha1_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ack;
  logic [63:0]  req_data;
  logic [159:0] rsp_digest, core_digest;
  logic         rsp_error, core_reset, core_on, core_finish, busy;
  logic [511:0] core_msg;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] words [16];
  bit finish_en = 1'b1;
  int mcnt;

  localparam logic [159:0] Sha1Abc  = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
  localparam logic [511:0] AbcBlock = {32'h00000018, 448'h0, 32'h61626380};

  always #5 clk = ~clk;

  sha1_sched #(.TIMEOUT(255), .NREQ(2)) dut (
    .wb_clk_i    (clk),
    .reset       (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ack     (rsp_ack),
    .rsp_digest  (rsp_digest),
    .rsp_error   (rsp_error),
    .core_reset  (core_reset),
    .core_on     (core_on),
    .core_msg    (core_msg),
    .core_digest (core_digest),
    .core_finish (core_finish),
    .busy        (busy)
  );

  // Engine model: real SHA-1 for the "abc" block, a word fold otherwise;
  // finishes on the 6th RUN cycle when enabled.
  function automatic logic [159:0] model_digest(input logic [511:0] m);
    logic [31:0] w [16];
    for (int k = 0; k < 16; k++) w[k] = m[32*k +: 32];
    if (m == AbcBlock) return Sha1Abc;
    return {w[0] ^ w[5] ^ w[10] ^ w[15], w[1] ^ w[6] ^ w[11], w[2] ^ w[7] ^ w[12],
            w[3] ^ w[8] ^ w[13], w[4] ^ w[9] ^ w[14]};
  endfunction

  function automatic logic [511:0] pack_words();
    logic [511:0] m;
    for (int k = 0; k < 16; k++) m[32*k +: 32] = words[k];
    return m;
  endfunction

  always_ff @(posedge clk) begin
    if (core_reset) mcnt <= 0;
    else if (core_on) mcnt <= mcnt + 1;
  end
  assign core_finish = finish_en && core_on && (mcnt == 5);
  assign core_digest = model_digest(core_msg);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [31:0] base, input logic [31:0] step);
    for (int k = 0; k < 16; k++) words[k] = base + step * k;
  endtask

  // Offers words[] on lane g until 16 are accepted; leaves the DUT in KICK.
  task automatic load_words(input int g, input bit stall, input bit keep_other);
    int i;
    int guard;
    bit v, acc, bad, seen;
    logic [1:0] gbit, other;
    i = 0; guard = 0; bad = 0; seen = 0;
    gbit  = (g == 0) ? 2'b01 : 2'b10;
    other = keep_other ? ~gbit : 2'b00;
    while (i < 16 && guard < 200) begin
      v = stall ? (guard % 2 == 0) : 1'b1;
      req_valid = (v ? gbit : 2'b00) | other;
      req_data  = (g == 0) ? {32'hdeadbeef, words[i]} : {words[i], 32'hdeadbeef};
      #1;
      if (req_ready == gbit) seen = 1;
      else if (seen || req_ready != 2'b00) bad = 1;
      acc = v && (req_ready == gbit);
      tick();
      guard++;
      if (acc) i++;
    end
    req_valid = other;
    n_total++;
    if (i !== 16) $display("FAIL load_count g=%0d: got %0d want 16", g, i);
    else n_pass++;
    n_total++;
    if (bad) $display("FAIL load_ready g=%0d: ready left grant before 16th word", g);
    else n_pass++;
    n_total++;
    if (req_ready !== 2'b00 || core_reset !== 1'b1 || core_on !== 1'b0)
      $display("FAIL kick g=%0d: got ready=%b rst=%b on=%b want 00/1/0",
               g, req_ready, core_reset, core_on);
    else n_pass++;
  endtask

  // From KICK: enter RUN, wait for RESP, check the result.
  task automatic run_check(input int g, input bit exp_err, input logic [159:0] exp_dig,
                           input int exp_cycles);
    int n;
    bit moved;
    logic [1:0] gbit;
    gbit = (g == 0) ? 2'b01 : 2'b10;
    n = 0; moved = 0;
    tick();
    n_total++;
    if (core_on !== 1'b1 || core_reset !== 1'b0)
      $display("FAIL run_entry g=%0d: got on=%b rst=%b want 1/0", g, core_on, core_reset);
    else n_pass++;
    n_total++;
    if (core_msg !== pack_words())
      $display("FAIL core_msg g=%0d: got %h want %h", g, core_msg, pack_words());
    else n_pass++;
    while (rsp_valid == 2'b00 && n < 400) begin
      if (core_msg !== pack_words()) moved = 1;
      tick();
      n++;
    end
    n_total++;
    if (rsp_valid !== gbit) $display("FAIL rsp_valid g=%0d: got %b want %b", g, rsp_valid, gbit);
    else n_pass++;
    n_total++;
    if (rsp_error !== exp_err)
      $display("FAIL rsp_error g=%0d: got %b want %b", g, rsp_error, exp_err);
    else n_pass++;
    n_total++;
    if (rsp_digest !== exp_dig)
      $display("FAIL rsp_digest g=%0d: got %h want %h", g, rsp_digest, exp_dig);
    else n_pass++;
    n_total++;
    if (moved || core_on !== 1'b0)
      $display("FAIL run_stable g=%0d: msg_moved=%b core_on=%b want 0/0", g, moved, core_on);
    else n_pass++;
    if (exp_cycles >= 0) begin
      n_total++;
      if (n !== exp_cycles) $display("FAIL run_cycles g=%0d: got %0d want %0d", g, n, exp_cycles);
      else n_pass++;
    end
  endtask

  task automatic do_ack(input int g);
    rsp_ack = (g == 0) ? 2'b01 : 2'b10;
    tick();
    rsp_ack = 2'b00;
    n_total++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00)
      $display("FAIL ack_idle g=%0d: got busy=%b rsp_valid=%b want 0/00", g, busy, rsp_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b00; rsp_ack = 2'b00; req_data = '0;
    tick(); tick();
    n_total++;
    if (busy !== 1'b0 || req_ready !== 2'b00 || rsp_valid !== 2'b00 || core_on !== 1'b0)
      $display("FAIL reset_ctrl: got busy=%b ready=%b rsp=%b on=%b want 0",
               busy, req_ready, rsp_valid, core_on);
    else n_pass++;
    n_total++;
    if (rsp_digest !== '0 || rsp_error !== 1'b0 || core_msg !== '0)
      $display("FAIL reset_data: got dig=%h err=%b msg=%h want 0", rsp_digest, rsp_error, core_msg);
    else n_pass++;
    n_total++;
    if (core_reset !== 1'b1) $display("FAIL reset_core_rst: got %b want 1", core_reset);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (core_reset !== 1'b1) $display("FAIL core_rst_hold: got %b want 1", core_reset);
    else n_pass++;
    tick();
    n_total++;
    if (core_reset !== 1'b0) $display("FAIL core_rst_drop: got %b want 0", core_reset);
    else n_pass++;
  endtask

  task automatic test_single_and_tie();
    for (int k = 0; k < 16; k++) words[k] = 32'h0;
    words[0]  = 32'h61626380;
    words[15] = 32'h00000018;
    load_words(0, 1'b0, 1'b1);
    run_check(0, 1'b0, Sha1Abc, 6);
    do_ack(0);
    tick();
    n_total++;
    if (req_ready !== 2'b10) $display("FAIL tie_second_grant: got %b want 10", req_ready);
    else n_pass++;
    set_words(32'h01000000, 32'h00010001);
    load_words(1, 1'b0, 1'b0);
    run_check(1, 1'b0, model_digest(pack_words()), 6);
    do_ack(1);
  endtask

  task automatic test_stall();
    set_words(32'h10000000, 32'h01010101);
    load_words(0, 1'b1, 1'b0);
    run_check(0, 1'b0, model_digest(pack_words()), 6);
    do_ack(0);
  endtask

  task automatic test_timeout();
    finish_en = 1'b0;
    set_words(32'hcafe0000, 32'h00000003);
    load_words(1, 1'b0, 1'b0);
    run_check(1, 1'b1, 160'h0, 255);
    do_ack(1);
    finish_en = 1'b1;
  endtask

  task automatic test_late_ack();
    logic [159:0] exp;
    bit bad;
    bad = 0;
    set_words(32'h0badf00d, 32'h11111111);
    exp = model_digest(pack_words());
    load_words(0, 1'b0, 1'b1);
    run_check(0, 1'b0, exp, 6);
    for (int c = 0; c < 50; c++) begin
      rsp_ack = (c == 10) ? 2'b10 : 2'b00;
      tick();
      if (rsp_digest !== exp || rsp_valid !== 2'b01 || req_ready !== 2'b00 || busy !== 1'b1)
        bad = 1;
    end
    rsp_ack = 2'b00;
    n_total++;
    if (bad) $display("FAIL late_ack_hold: result or grant changed before ack (dig=%h)", rsp_digest);
    else n_pass++;
    do_ack(0);
    tick();
    n_total++;
    if (req_ready !== 2'b10) $display("FAIL late_ack_next: got %b want 10", req_ready);
    else n_pass++;
    set_words(32'h76543210, 32'h00100000);
    load_words(1, 1'b0, 1'b0);
    run_check(1, 1'b0, model_digest(pack_words()), 6);
    do_ack(1);
  endtask

  task automatic test_reset_mid_run();
    bit stray;
    stray = 0;
    finish_en = 1'b0;
    set_words(32'haaaa0000, 32'h00000101);
    load_words(1, 1'b0, 1'b0);
    repeat (10) tick();
    rst = 1'b1;
    #1;
    n_total++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00 || core_on !== 1'b0 || core_msg !== '0)
      $display("FAIL mid_run_reset: got busy=%b rsp=%b on=%b msg_zero=%b want 0/00/0/1",
               busy, rsp_valid, core_on, core_msg == '0);
    else n_pass++;
    tick(); tick();
    rst = 1'b0;
    finish_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (rsp_valid !== 2'b00 || busy !== 1'b0) stray = 1;
    end
    n_total++;
    if (stray) $display("FAIL aborted_rsp: response or activity after reset, rsp=%b", rsp_valid);
    else n_pass++;
    set_words(32'h55550000, 32'h00020003);
    load_words(1, 1'b0, 1'b0);
    run_check(1, 1'b0, model_digest(pack_words()), 6);
    do_ack(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_and_tie();
    test_stall();
    test_timeout();
    test_late_ack();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
